// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory access controller and the core decode stage.
// Holds the command opcodes, the FSM state codes and the default sizes.
package dmem_pkg;

  localparam int DEF_DATA_W    = 16;
  localparam int DEF_ADDR_W    = 16;
  localparam int DEF_LEN_W     = 8;
  localparam int DEF_MEM_DEPTH = 10;

  typedef logic [1:0] op_t;
  typedef logic [1:0] state_t;

  localparam op_t OP_LOAD  = 2'b00;
  localparam op_t OP_STORE = 2'b01;
  localparam op_t OP_COPY  = 2'b10;
  localparam op_t OP_FILL  = 2'b11;

  localparam state_t ST_IDLE = 2'b00;
  localparam state_t ST_RD   = 2'b01;
  localparam state_t ST_WR   = 2'b10;
  localparam state_t ST_RESP = 2'b11;

  // COPY and FILL are the multi-word commands that honour req_len.
  function automatic logic is_block_op(input op_t op);
    return op[1];
  endfunction

endpackage

// File: rtl/dmem_range_chk.sv
// Combinational range check for a memory command.
// Sums are widened by one bit beyond address+length so no wrap can hide an overflow.
module dmem_range_chk #(
  parameter int ADDR_W    = dmem_pkg::DEF_ADDR_W,
  parameter int LEN_W     = dmem_pkg::DEF_LEN_W,
  parameter int MEM_DEPTH = dmem_pkg::DEF_MEM_DEPTH
) (
  input  logic [1:0]        op,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [LEN_W-1:0]  len,
  output logic              err
);
  import dmem_pkg::*;

  localparam int SUM_W = ADDR_W + LEN_W + 1;

  logic [SUM_W-1:0] end_a;
  logic [SUM_W-1:0] end_b;
  logic [SUM_W-1:0] depth;

  assign end_a = SUM_W'(addr_a) + SUM_W'(len);
  assign end_b = SUM_W'(addr_b) + SUM_W'(len);
  assign depth = SUM_W'(MEM_DEPTH);

  always_comb begin
    err = 1'b0;
    case (op)
      OP_LOAD, OP_STORE: err = (SUM_W'(addr_a) >= depth);
      OP_COPY:           err = (end_a > depth) || (end_b > depth);
      default:           err = (end_b > depth);
    endcase
  end

endmodule

// File: rtl/dmem_access_ctrl.sv
// Initiator-side controller for the single-port data memory: runs LOAD/STORE/COPY/FILL
// as RD/WR cycle sequences and returns one response pulse per command.
module dmem_access_ctrl #(
  parameter int DATA_W    = dmem_pkg::DEF_DATA_W,
  parameter int ADDR_W    = dmem_pkg::DEF_ADDR_W,
  parameter int LEN_W     = dmem_pkg::DEF_LEN_W,
  parameter int MEM_DEPTH = dmem_pkg::DEF_MEM_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr_a,
  input  logic [ADDR_W-1:0] req_addr_b,
  input  logic [LEN_W-1:0]  req_len,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_data,
  output logic              resp_err,
  output logic              mem_wr_en,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  import dmem_pkg::*;

  state_t            state_reg;
  op_t               op_reg;
  logic [ADDR_W-1:0] addr_a_reg;
  logic [ADDR_W-1:0] addr_b_reg;
  logic [LEN_W-1:0]  len_reg;
  logic [LEN_W-1:0]  cnt_reg;
  logic              err_reg;
  logic [ADDR_W-1:0] mem_addr_reg;
  logic [DATA_W-1:0] mem_wdata_reg;
  logic [DATA_W-1:0] resp_data_reg;

  logic              range_err;
  logic              last_word;
  logic [ADDR_W-1:0] cnt_ext;
  logic [ADDR_W-1:0] cnt_inc;

  dmem_range_chk #(
    .ADDR_W   (ADDR_W),
    .LEN_W    (LEN_W),
    .MEM_DEPTH(MEM_DEPTH)
  ) u_range_chk (
    .op    (req_op),
    .addr_a(req_addr_a),
    .addr_b(req_addr_b),
    .len   (req_len),
    .err   (range_err)
  );

  assign last_word = (cnt_reg == len_reg - LEN_W'(1));
  assign cnt_ext   = ADDR_W'(cnt_reg);
  assign cnt_inc   = ADDR_W'(cnt_reg) + ADDR_W'(1);

  assign req_ready  = (state_reg == ST_IDLE);
  assign resp_valid = (state_reg == ST_RESP);
  assign resp_err   = (state_reg == ST_RESP) && err_reg;
  assign mem_rd_en  = (state_reg == ST_RD);
  assign mem_wr_en  = (state_reg == ST_WR);
  assign mem_addr   = mem_addr_reg;
  assign mem_wdata  = mem_wdata_reg;
  assign resp_data  = resp_data_reg;

  // mem_addr/mem_wdata are loaded on entry to RD/WR so they hold in IDLE and RESP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      op_reg        <= OP_LOAD;
      addr_a_reg    <= '0;
      addr_b_reg    <= '0;
      len_reg       <= '0;
      cnt_reg       <= '0;
      err_reg       <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
      resp_data_reg <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (req_valid) begin
            op_reg     <= req_op;
            addr_a_reg <= req_addr_a;
            addr_b_reg <= req_addr_b;
            len_reg    <= req_len;
            cnt_reg    <= '0;
            err_reg    <= range_err;
            if (range_err || (is_block_op(req_op) && req_len == '0)) begin
              state_reg <= ST_RESP;
            end else begin
              case (req_op)
                OP_LOAD: begin
                  state_reg    <= ST_RD;
                  mem_addr_reg <= req_addr_a;
                end
                OP_STORE: begin
                  state_reg     <= ST_WR;
                  mem_addr_reg  <= req_addr_a;
                  mem_wdata_reg <= req_wdata;
                end
                OP_COPY: begin
                  state_reg    <= ST_RD;
                  mem_addr_reg <= req_addr_a;
                end
                default: begin
                  state_reg     <= ST_WR;
                  mem_addr_reg  <= req_addr_b;
                  mem_wdata_reg <= req_wdata;
                end
              endcase
            end
          end
        end
        ST_RD: begin
          if (op_reg == OP_LOAD) begin
            resp_data_reg <= mem_rdata;
            state_reg     <= ST_RESP;
          end else begin
            // The write-data register doubles as the COPY word buffer.
            mem_wdata_reg <= mem_rdata;
            mem_addr_reg  <= addr_b_reg + cnt_ext;
            state_reg     <= ST_WR;
          end
        end
        ST_WR: begin
          if (op_reg == OP_STORE || last_word) begin
            state_reg <= ST_RESP;
          end else begin
            cnt_reg <= cnt_reg + LEN_W'(1);
            if (op_reg == OP_FILL) begin
              mem_addr_reg <= addr_b_reg + cnt_inc;
            end else begin
              mem_addr_reg <= addr_a_reg + cnt_inc;
              state_reg    <= ST_RD;
            end
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed bench for dmem_access_ctrl with a 10-word memory model that resets to 16384+addr.
module tb_dmem_access_ctrl;

  localparam logic [1:0] LOAD  = 2'b00;
  localparam logic [1:0] STORE = 2'b01;
  localparam logic [1:0] COPY  = 2'b10;
  localparam logic [1:0] FILL  = 2'b11;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [15:0] req_addr_a;
  logic [15:0] req_addr_b;
  logic [7:0]  req_len;
  logic [15:0] req_wdata;
  logic        resp_valid;
  logic [15:0] resp_data;
  logic        resp_err;
  logic        mem_wr_en;
  logic        mem_rd_en;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;

  logic [15:0] mem [10];

  int checks;
  int failures;
  logic [33:0] exp_ev[$];
  logic [33:0] obs_ev[$];

  dmem_access_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_addr_a(req_addr_a),
    .req_addr_b(req_addr_b),
    .req_len   (req_len),
    .req_wdata (req_wdata),
    .resp_valid(resp_valid),
    .resp_data (resp_data),
    .resp_err  (resp_err),
    .mem_wr_en (mem_wr_en),
    .mem_rd_en (mem_rd_en),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 10; i++) mem[i] <= 16'(16384 + i);
    end else if (mem_wr_en && mem_addr < 16'd10) begin
      mem[mem_addr[3:0]] <= mem_wdata;
    end
  end

  always_comb mem_rdata = (mem_addr < 16'd10) ? mem[mem_addr[3:0]] : 16'h0000;

  task automatic check(input string tag, input logic [33:0] obs, input logic [33:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic exp_rd(input logic [15:0] a);
    exp_ev.push_back({1'b1, 1'b0, a, 16'h0000});
  endtask

  task automatic exp_wr(input logic [15:0] a, input logic [15:0] d);
    exp_ev.push_back({1'b0, 1'b1, a, d});
  endtask

  // Issue one command, wait for its response and compare latency, flags, data and memory cycles.
  task automatic run_cmd(input string tag, input logic [1:0] op, input logic [15:0] a,
                         input logic [15:0] b, input logic [7:0] len, input logic [15:0] wd,
                         input int exp_lat, input logic exp_err, input logic [15:0] exp_data);
    int k;
    logic got;
    int n;
    @(negedge clk);
    check({tag, " ready"}, 34'(req_ready), 34'(1));
    req_valid  = 1'b1;
    req_op     = op;
    req_addr_a = a;
    req_addr_b = b;
    req_len    = len;
    req_wdata  = wd;
    @(posedge clk);
    #1 req_valid = 1'b0;
    obs_ev.delete();
    k = 0;
    got = 1'b0;
    while (!got && k < 100) begin
      @(negedge clk);
      k++;
      if (mem_rd_en || mem_wr_en) begin
        check({tag, " excl"}, 34'(mem_rd_en & mem_wr_en), 34'(0));
        obs_ev.push_back({mem_rd_en, mem_wr_en, mem_addr, mem_wr_en ? mem_wdata : 16'h0000});
      end
      if (resp_valid) got = 1'b1;
    end
    check({tag, " latency"}, 34'(k), 34'(exp_lat));
    check({tag, " err"}, 34'(resp_err), 34'(exp_err));
    check({tag, " data"}, 34'(resp_data), 34'(exp_data));
    check({tag, " ncycles"}, 34'(obs_ev.size()), 34'(exp_ev.size()));
    n = (obs_ev.size() < exp_ev.size()) ? obs_ev.size() : exp_ev.size();
    for (int i = 0; i < n; i++) check($sformatf("%s cycle%0d", tag, i), obs_ev[i], exp_ev[i]);
    $display("txn %s op=%0d a=%0d b=%0d len=%0d lat=%0d err=%0b data=%h", tag, op, a, b, len, k,
             resp_err, resp_data);
    exp_ev.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " req_ready"}, 34'(req_ready), 34'(1));
    check({tag, " resp_valid"}, 34'(resp_valid), 34'(0));
    check({tag, " resp_err"}, 34'(resp_err), 34'(0));
    check({tag, " resp_data"}, 34'(resp_data), 34'(0));
    check({tag, " enables"}, 34'({mem_rd_en, mem_wr_en}), 34'(0));
    check({tag, " mem_addr"}, 34'(mem_addr), 34'(0));
    check({tag, " mem_wdata"}, 34'(mem_wdata), 34'(0));
  endtask

  initial begin
    logic [7:0] resp_mask;
    logic [7:0] ready_mask;
    int nwr;
    checks = 0;
    failures = 0;
    req_valid = 1'b0;
    req_op = LOAD;
    req_addr_a = '0;
    req_addr_b = '0;
    req_len = '0;
    req_wdata = '0;
    do_reset();
    check_reset_outputs("reset");

    exp_rd(16'd3);
    run_cmd("load3", LOAD, 16'd3, 16'd0, 8'd0, 16'h0, 2, 1'b0, 16'd16387);
    exp_wr(16'd7, 16'hBEEF);
    run_cmd("store7", STORE, 16'd7, 16'd0, 8'd0, 16'hBEEF, 2, 1'b0, 16'd16387);
    exp_rd(16'd7);
    run_cmd("load7", LOAD, 16'd7, 16'd0, 8'd0, 16'h0, 2, 1'b0, 16'hBEEF);
    for (int i = 2; i < 6; i++) exp_wr(16'(i), 16'h00AA);
    run_cmd("fill2x4", FILL, 16'd0, 16'd2, 8'd4, 16'h00AA, 5, 1'b0, 16'hBEEF);
    exp_rd(16'd6);
    run_cmd("load6", LOAD, 16'd6, 16'd0, 8'd0, 16'h0, 2, 1'b0, 16'd16390);
    exp_rd(16'd4);
    run_cmd("load4", LOAD, 16'd4, 16'd0, 8'd0, 16'h0, 2, 1'b0, 16'h00AA);

    do_reset();
    for (int i = 0; i < 3; i++) begin
      exp_rd(16'(i));
      exp_wr(16'(5 + i), 16'(16384 + i));
    end
    run_cmd("copy0to5x3", COPY, 16'd0, 16'd5, 8'd3, 16'h0, 7, 1'b0, 16'd0);
    for (int i = 5; i < 8; i++) begin
      exp_rd(16'(i));
      run_cmd($sformatf("load%0d", i), LOAD, 16'(i), 16'd0, 8'd0, 16'h0, 2, 1'b0, 16'(16384 + i - 5));
    end
    // Overlapping ascending copy propagates word 0 forward.
    exp_rd(16'd0); exp_wr(16'd1, 16'd16384);
    exp_rd(16'd1); exp_wr(16'd2, 16'd16384);
    run_cmd("copy0to1x2", COPY, 16'd0, 16'd1, 8'd2, 16'h0, 5, 1'b0, 16'd16386);
    exp_rd(16'd2);
    run_cmd("load2", LOAD, 16'd2, 16'd0, 8'd0, 16'h0, 2, 1'b0, 16'd16384);

    run_cmd("copy_src_oob", COPY, 16'd8, 16'd0, 8'd3, 16'h0, 1, 1'b1, 16'd16384);
    run_cmd("load10", LOAD, 16'd10, 16'd0, 8'd0, 16'h0, 1, 1'b1, 16'd16384);
    run_cmd("fill_len0", FILL, 16'd0, 16'd0, 8'd0, 16'h1111, 1, 1'b0, 16'd16384);
    run_cmd("loadffff", LOAD, 16'hFFFF, 16'd0, 8'd0, 16'h0, 1, 1'b1, 16'd16384);
    run_cmd("copy_dst_oob", COPY, 16'd0, 16'd8, 8'd3, 16'h0, 1, 1'b1, 16'd16384);
    run_cmd("fill_wrap", FILL, 16'd0, 16'hFFFF, 8'hFF, 16'h0, 1, 1'b1, 16'd16384);
    exp_wr(16'd9, 16'h7777);
    run_cmd("fill9x1", FILL, 16'd0, 16'd9, 8'd1, 16'h7777, 2, 1'b0, 16'd16384);
    exp_rd(16'd9);
    run_cmd("load9", LOAD, 16'd9, 16'd0, 8'd0, 16'h0, 2, 1'b0, 16'h7777);

    // req_valid held through a FILL: the second acceptance waits for IDLE.
    @(negedge clk);
    req_valid  = 1'b1;
    req_op     = FILL;
    req_addr_a = 16'd0;
    req_addr_b = 16'd8;
    req_len    = 8'd2;
    req_wdata  = 16'h5555;
    resp_mask  = '0;
    ready_mask = '0;
    nwr = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      resp_mask[k-1]  = resp_valid;
      ready_mask[k-1] = req_ready;
      if (mem_wr_en) nwr++;
      if (k == 5) req_valid = 1'b0;
    end
    check("held resp_mask", 34'(resp_mask), 34'(8'b0100_0100));
    check("held ready_mask", 34'(ready_mask), 34'(8'b1000_1000));
    check("held writes", 34'(nwr), 34'(4));
    $display("txn held_fill resp_mask=%b ready_mask=%b writes=%0d", resp_mask, ready_mask, nwr);
    exp_rd(16'd8);
    run_cmd("load8", LOAD, 16'd8, 16'd0, 8'd0, 16'h0, 2, 1'b0, 16'h5555);

    // Reset asserted mid-FILL, while the second word is being written.
    @(negedge clk);
    req_valid  = 1'b1;
    req_op     = FILL;
    req_addr_a = 16'd0;
    req_addr_b = 16'd0;
    req_len    = 8'd5;
    req_wdata  = 16'h1234;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("midfill wr_en", 34'(mem_wr_en), 34'(1));
    check("midfill addr", 34'(mem_addr), 34'(1));
    #1 rst = 1'b1;
    #1 check_reset_outputs("async_rst");
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check("rst_hold resp_valid", 34'(resp_valid), 34'(0));
    end
    rst = 1'b0;
    $display("txn async_rst mem_addr=%0d req_ready=%0b", mem_addr, req_ready);
    exp_rd(16'd0);
    run_cmd("load0_after_rst", LOAD, 16'd0, 16'd0, 8'd0, 16'h0, 2, 1'b0, 16'd16384);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
